mux_txn_sequencer: RTL

- Upstream/downstream companion to the 2:1 mux stage. Buffers operand transactions (a, b, sel) arriving on a valid/ready stream in a small FIFO.
- Drives the FIFO head onto the mux operand lines. Captures the mux result into a registered output stage that has its own valid/ready handshake.
- Turns the purely combinational mux into a flow-controlled, pipelined datapath at one transaction per cycle.

---
 rtl/mux_txn_sequencer.sv | 90 +++++++++
 1 files changed

// File: rtl/mux_txn_sequencer.sv
// Flow-controlled wrapper around an external combinational 2:1 mux: operand FIFO in,
// registered result stage out, one transaction per cycle.
module mux_txn_sequencer #(
  parameter  int DATA_WITH  = 12,
  parameter  int FIFO_DEPTH = 4,
  localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [DATA_WITH-1:0] i_a,
  input  logic [DATA_WITH-1:0] i_b,
  input  logic                 i_sel,
  output logic [DATA_WITH-1:0] o_mux_a,
  output logic [DATA_WITH-1:0] o_mux_b,
  output logic                 o_mux_sel,
  input  logic [DATA_WITH-1:0] i_mux_y,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [DATA_WITH-1:0] o_y,
  output logic [CW-1:0]        o_count
);

  localparam int            PW   = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [DATA_WITH-1:0] a;
    logic [DATA_WITH-1:0] b;
    logic                 sel;
  } txn_t;

  txn_t                 mem [FIFO_DEPTH];
  txn_t                 head;
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 out_vld;
  logic [DATA_WITH-1:0] out_y;
  logic                 push, pop, empty;

  assign empty   = (count == '0);
  // ready looks only at occupancy, so a same-cycle pop never opens a slot
  assign o_ready = !i_rst && (count != FULL);
  assign push    = i_valid && o_ready;
  assign pop     = !empty && (!out_vld || i_ready);

  always_comb begin
    head = '0;
    if (!empty) head = mem[rd_ptr];
  end

  assign o_mux_a   = head.a;
  assign o_mux_b   = head.b;
  assign o_mux_sel = head.sel;

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= '{a: i_a, b: i_b, sel: i_sel};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      out_vld <= 1'b0;
      out_y   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // capture the mux result for the head as it leaves; otherwise hold or retire
      if (pop) begin
        out_y   <= i_mux_y;
        out_vld <= 1'b1;
      end else if (out_vld && i_ready) begin
        out_vld <= 1'b0;
      end
    end
  end

  assign o_valid = out_vld;
  assign o_y     = out_y;
  assign o_count = count;

endmodule
